// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU with a start/done handshake.
//
// Single-cycle ops (AND, OR, ADD, XOR, SHL, SHR, SUB) pass through EXEC.
// MUL passes through MUL for WIDTH shift-add iterations plus one cycle
// that registers the result.
// result and sreg only change on the edge that enters DONE.
//
// Ports:
//   clk     : sole clock, rising edge
//   rst_n   : synchronous active-low reset
//   start   : request, accepted only in IDLE or DONE
//   ALUOp   : operation select (latched on accept)
//   a, b    : operands (latched on accept)
//   result  : registered result
//   sreg    : registered status {V,N,Z,C}
//   busy    : high in EXEC and MUL
//   done    : one-cycle pulse in DONE
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ALUOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       sreg,
    output logic             busy,
    output logic             done
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [2:0]         op_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] prod_reg;

    logic accept;
    assign accept = start && (state_reg == IDLE || state_reg == DONE);
    assign busy   = (state_reg == EXEC) || (state_reg == MUL);
    assign done   = (state_reg == DONE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) state_next = (ALUOp == OP_MUL) ? MUL : EXEC;
                else       state_next = IDLE;
            end
            EXEC:    state_next = DONE;
            MUL:     if (cnt_reg == CNT_LAST) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- bitwise ops ----------------
    logic [WIDTH-1:0] and_v, or_v, xor_v;
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_v[gi] = a_reg[gi] & b_reg[gi];
            assign or_v[gi]  = a_reg[gi] | b_reg[gi];
            assign xor_v[gi] = a_reg[gi] ^ b_reg[gi];
        end
    endgenerate

    // ---------------- single-cycle datapath ----------------
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
    logic [WIDTH-1:0] exec_res;
    logic             exec_c, exec_v;

    assign shamt = b_reg[SHW-1:0];
    assign add_w = {1'b0, a_reg} + {1'b0, b_reg};
    // Bit WIDTH of the extended difference is the unsigned borrow.
    assign sub_w = {1'b0, a_reg} - {1'b0, b_reg};
    // One guard bit catches the last bit shifted out; it stays 0 for shamt 0.
    assign shl_w = {1'b0, a_reg} << shamt;
    assign shr_w = {a_reg, 1'b0} >> shamt;

    always_comb begin
        exec_res = '0;
        exec_c   = 1'b0;
        exec_v   = 1'b0;
        case (op_reg)
            OP_AND: exec_res = and_v;
            OP_OR:  exec_res = or_v;
            OP_XOR: exec_res = xor_v;
            OP_ADD: begin
                exec_res = add_w[WIDTH-1:0];
                exec_c   = add_w[WIDTH];
                exec_v   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (add_w[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                exec_res = sub_w[WIDTH-1:0];
                exec_c   = sub_w[WIDTH];
                exec_v   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                           (sub_w[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SHL: begin
                exec_res = shl_w[WIDTH-1:0];
                exec_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                exec_res = shr_w[WIDTH:1];
                exec_c   = shr_w[0];
            end
            default: ;
        endcase
    end

    // ---------------- shift-add multiplier ----------------
    // prod_reg = {accumulator, multiplier}. Each step adds the multiplicand
    // into the upper half when the multiplier LSB is set, then shifts the
    // whole pair right; after WIDTH steps it holds the full product.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} +
                     {1'b0, (prod_reg[0] ? a_reg : {WIDTH{1'b0}})};

    // ---------------- final result selection ----------------
    logic [WIDTH-1:0] fin_res;
    logic             fin_c, fin_v, fin_load;

    always_comb begin
        fin_res = exec_res;
        fin_c   = exec_c;
        fin_v   = exec_v;
        if (state_reg == MUL) begin
            fin_res = prod_reg[WIDTH-1:0];
            fin_c   = |prod_reg[2*WIDTH-1:WIDTH];
            fin_v   = 1'b0;
        end
    end

    assign fin_load = (state_reg == EXEC) ||
                      (state_reg == MUL && cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            cnt_reg  <= '0;
            prod_reg <= '0;
            result   <= '0;
            sreg     <= '0;
        end else begin
            if (accept) begin
                a_reg    <= a;
                b_reg    <= b;
                op_reg   <= ALUOp;
                cnt_reg  <= '0;
                prod_reg <= {{WIDTH{1'b0}}, b};
            end else if (state_reg == MUL && cnt_reg != CNT_LAST) begin
                prod_reg <= {mul_sum, prod_reg[WIDTH-1:1]};
                cnt_reg  <= cnt_reg + 1'b1;
            end
            if (fin_load) begin
                result <= fin_res;
                sreg   <= {fin_v, fin_res[WIDTH-1], (fin_res == '0), fin_c};
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=16) with a scoreboard queue of expected
// {sreg,result} values, filled on drive and drained on the done pulse.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  ALUOp;
    logic [15:0] a, b;
    logic [15:0] result;
    logic [3:0]  sreg;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    logic [19:0] sb_q[$];

    alu_mc #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(ALUOp),
        .a(a), .b(b), .result(result), .sreg(sreg), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {V,N,Z,C,result}.
    function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] w;
        logic [15:0] r;
        logic        c, v;
        int          sx, sy, s;
        logic [3:0]  sh;
        sh = y[3:0];
        sx = int'($signed(x));
        sy = int'($signed(y));
        c = 1'b0; v = 1'b0; r = '0; w = '0;
        case (op)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd3: r = x ^ y;
            3'd2: begin
                w = 32'(x) + 32'(y); r = w[15:0]; c = w[16];
                s = sx + sy; v = (s > 32767) || (s < -32768);
            end
            3'd6: begin
                r = x - y; c = (x < y);
                s = sx - sy; v = (s > 32767) || (s < -32768);
            end
            3'd4: begin w = 32'(x) << sh; r = w[15:0]; c = w[16]; end
            3'd5: begin w = {x, 16'h0} >> sh; r = w[31:16]; c = (sh != 0) && w[15]; end
            default: begin w = 32'(x) * 32'(y); r = w[15:0]; c = (w[31:16] != 0); end
        endcase
        return {v, r[15], (r == 16'h0), c, r};
    endfunction

    // Issue one op, scramble inputs while it runs, check latency/busy/result.
    task automatic run_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                          input int lat, input bit pulse);
        int edges = 0;
        int busy_cycles = 0;
        bit seen = 0;
        logic [19:0] exp;
        sb_q.push_back(model(op, x, y));
        @(negedge clk);
        start = 1'b1; ALUOp = op; a = x; b = y;
        while (!seen && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (pulse && edges == 5) begin
                start = 1'b1; ALUOp = 3'b010;
            end else begin
                start = 1'b0; ALUOp = 3'($urandom_range(0, 7));
            end
            a = 16'($urandom); b = 16'($urandom);
            if (busy) busy_cycles++;
            if (done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(edges), 32'(lat));
        chk("busy_cycles", 32'(busy_cycles), 32'(lat - 1));
        exp = sb_q.pop_front();
        chk("result", 32'(result), 32'(exp[15:0]));
        chk("sreg", 32'(sreg), 32'(exp[19:16]));
        $display("op=%0d a=%h b=%h result=%h sreg=%b edges=%0d", op, x, y, result, sreg, edges);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("result_hold", 32'(result), 32'(exp[15:0]));
    endtask

    initial begin
        logic [19:0] exp;
        int done_cnt;
        // Reset with start asserted: reset must win.
        rst_n = 1'b0; start = 1'b1; ALUOp = 3'b010; a = 16'h1234; b = 16'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_sreg", 32'(sreg), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1; start = 1'b0;

        run_op(3'b010, 16'hFFFF, 16'h0001, 2, 0);   // ADD carry -> 0, 0011
        run_op(3'b110, 16'd15,   16'd15,   2, 0);   // SUB -> 0, 0010
        run_op(3'b110, 16'd15,   16'd16,   2, 0);   // SUB borrow -> FFFF, 0101
        run_op(3'b010, 16'h7FFF, 16'h0001, 2, 0);   // ADD overflow -> 8000, 1100
        run_op(3'b100, 16'h8001, 16'h0001, 2, 0);   // SHL -> 0002, 0001
        run_op(3'b100, 16'h8001, 16'h0010, 2, 0);   // SHL amount 0 (high b bits ignored)
        run_op(3'b101, 16'h8001, 16'h0011, 2, 0);   // SHR by 1
        run_op(3'b011, 16'hA5A5, 16'hFFFF, 2, 0);   // XOR
        run_op(3'b000, 16'hF0F0, 16'h0F0F, 2, 0);   // AND -> 0
        run_op(3'b111, 16'd300,  16'd300,  18, 1);  // MUL with ignored ADD pulse
        run_op(3'b111, 16'hFFFF, 16'hFFFF, 18, 0);  // MUL full-range

        // Back-to-back: start held through DONE.
        sb_q.push_back(model(3'b010, 16'd1, 16'd2));
        sb_q.push_back(model(3'b000, 16'd7, 16'd1));
        @(negedge clk);
        start = 1'b1; ALUOp = 3'b010; a = 16'd1; b = 16'd2;
        @(posedge clk); @(negedge clk);
        ALUOp = 3'b000; a = 16'd7; b = 16'd1;
        @(posedge clk); @(negedge clk);
        chk("b2b_done1", 32'(done), 32'd1);
        exp = sb_q.pop_front();
        chk("b2b_result1", 32'(result), 32'(exp[15:0]));
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_no_idle_done", 32'(done), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("b2b_done2", 32'(done), 32'd1);
        exp = sb_q.pop_front();
        chk("b2b_result2", 32'(result), 32'(exp[15:0]));
        chk("b2b_sreg2", 32'(sreg), 32'(exp[19:16]));
        $display("back-to-back AND a=7 b=1 result=%h sreg=%b", result, sreg);

        // Reset during MUL.
        @(negedge clk);
        start = 1'b1; ALUOp = 3'b111; a = 16'd300; b = 16'd300;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_sreg", 32'(sreg), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (20) begin
            @(posedge clk); @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        $display("reset during MUL: result=%h sreg=%b busy=%b", result, sreg, busy);
        run_op(3'b001, 16'd5, 16'd2, 2, 0);         // OR -> 7

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
